regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-port integer register file for the pipelined core. It generalises the single-cycle two-read/one-write file to NRD read ports and two write ports, with an optional write-to-read bypass. It also holds an integrated scoreboard (busy bit per register) that issue logic uses for RAW/WAW hazard detection. It sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2); register 0 hardwired to zero
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only committed state
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rs_addr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rs_data_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rs_busy_o  out  NRD  read register k has an outstanding producer
we_i  in  2  write enables, writeback ports 0 and 1
wa_i  in  2*AW  write addresses
wd_i  in  2*XLEN  write data
alloc_valid_i  in  1  issue requests to mark alloc_rd_i busy
alloc_rd_i  in  AW  destination register being allocated
alloc_ready_o  out  1  allocation can be accepted this cycle

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low. Asserting rst_n low clears all registers to 0 and all busy bits to 0 immediately, regardless of clk. Release is synchronised externally.
- Reset values: rs_data_o = 0, rs_busy_o = 0, alloc_ready_o = 1.
- Reads are combinational with zero latency. Address 0 always returns 0 and busy 0.
- Writes: on the rising edge, regs[wa] <= wd when we and wa != 0. If both ports write the same address, port 1 wins. Register 0 is never written.
- Bypass (BYPASS=1): if a write port writes rs_addr (nonzero) this cycle, rs_data_o returns that wd_i, with port-1 priority. With BYPASS=0, the old value is returned until the next cycle.
- Scoreboard: busy[r] is set on the edge when alloc_valid_i & alloc_ready_o & alloc_rd_i == r & r != 0. busy[r] is cleared on the edge when any write port writes r.
  - Same-cycle set and clear of the same r: set wins, so busy stays 1 (new producer).
  - Allocation of r = 0 is accepted with no state change.
- rs_busy_o[k] = busy[rs_addr_k] & ~(clearing write to rs_addr_k this cycle). The clearing term applies only when BYPASS=1; with BYPASS=0, rs_busy_o[k] = busy[rs_addr_k].
- alloc_ready_o = ~busy[alloc_rd_i] | (write to alloc_rd_i this cycle) | (alloc_rd_i == 0). This blocks WAW until the prior producer writes back. alloc_ready_o does not depend on alloc_valid_i (no combinational loop).
- A write to a non-busy register is legal: data is updated and busy is unaffected.
- Out-of-range addresses cannot occur (NREGS is a power of two).

Decomposition:
- Package regfile_pkg: localparams XLEN_DEF=32 and NREGS_DEF=32; function clog2-based AW; typedef reg_addr_t (logic [AW-1:0]); typedef xlen_t.
- Sub-module regfile_scoreboard holds the busy vector, the set/clear priority, and alloc_ready_o / busy lookup for NRD ports. The top module holds the storage array, write arbitration and bypass muxes.

Test Plan:
- Reset then read: rst_n low mid-cycle, then high; read r5 -> 0, rs_busy 0, alloc_ready 1. State is cleared asynchronously before the next edge.
- Dual write conflict: we=2'b11, wa0=wa1=7, wd0=0x11, wd1=0x22 -> next cycle r7 reads 0x22. Write to r0 of 0xFFFF -> r0 reads 0.
- Bypass: BYPASS=1, write r3=0xABCD with rs_addr0=3 in the same cycle -> rs_data 0xABCD combinationally. BYPASS=0 -> old value that cycle, 0xABCD next cycle.
- Scoreboard RAW: alloc r9 accepted -> rs_busy for r9 is 1. Write r9=0x5 -> busy cleared that edge. With BYPASS=1, rs_busy 0 and data 0x5 in the write cycle.
- WAW block: r9 busy, alloc r9 with no write -> alloc_ready 0, busy unchanged. Same request with a write to r9 that cycle -> accepted, busy stays 1 (set wins).
- NRD=4 parametrisation: four ports reading r0, r1, r1, r31 after writes r1=1, r31=0xFFFFFFFF -> returns 0, 1, 1, 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per architectural register: allocation by issue, release by writeback,
// plus the per-read-port busy lookup and the WAW allocation gate.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rs_addr_i,
    input  logic [1:0]        we_i,
    input  logic [2*AW-1:0]   wa_i,
    input  logic              alloc_valid_i,
    input  logic [AW-1:0]     alloc_rd_i,
    output logic [NRD-1:0]    rs_busy_o,
    output logic              alloc_ready_o
);

    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic             alloc_set_s;

    function automatic logic wr_hit(input logic [1:0] we, input logic [2*AW-1:0] wa,
                                    input logic [AW-1:0] a);
        return (we[0] && (wa[0 +: AW] == a)) || (we[1] && (wa[AW +: AW] == a));
    endfunction

    // Allocation gate: a busy destination may be reallocated only as its producer retires.
    always_comb begin
        alloc_ready_o = ~busy_r[alloc_rd_i] | wr_hit(we_i, wa_i, alloc_rd_i)
                        | (alloc_rd_i == '0);
        alloc_set_s   = alloc_valid_i & alloc_ready_o & (alloc_rd_i != '0);
    end

    // Next busy vector; a new allocation outranks a same-edge writeback release.
    always_comb begin
        busy_nxt_s    = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (alloc_set_s && (alloc_rd_i == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (wr_hit(we_i, wa_i, AW'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port busy lookup; with bypass a retiring producer already counts as done.
    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rs_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rs_addr_i[k*AW +: AW];
            if (ra == '0) begin
                rs_busy_o[k] = 1'b0;
            end else if (BYP_EN && wr_hit(we_i, wa_i, ra)) begin
                rs_busy_o[k] = 1'b0;
            end else begin
                rs_busy_o[k] = busy_r[ra];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, two writeback ports,
// optional write-to-read bypass and an integrated hazard scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic [1:0]          we_i,
    input  logic [2*AW-1:0]     wa_i,
    input  logic [2*XLEN-1:0]   wd_i,
    input  logic                alloc_valid_i,
    input  logic [AW-1:0]       alloc_rd_i,
    output logic                alloc_ready_o
);

    localparam bit BYP_EN = (BYPASS != 32'sd0);

    logic [XLEN-1:0] regs_r [NREGS];

    // Storage; port 1 is written last so it wins an address collision, r0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
        end else begin
            if (we_i[0] && (wa_i[0 +: AW] != '0)) begin
                regs_r[wa_i[0 +: AW]] <= wd_i[0 +: XLEN];
            end
            if (we_i[1] && (wa_i[AW +: AW] != '0)) begin
                regs_r[wa_i[AW +: AW]] <= wd_i[XLEN +: XLEN];
            end
        end
    end

    // Read muxes with optional same-cycle forwarding, port 1 first.
    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rs_data_o = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rs_addr_i[k*AW +: AW];
            if (ra == '0) begin
                rs_data_o[k*XLEN +: XLEN] = '0;
            end else if (BYP_EN && we_i[1] && (wa_i[AW +: AW] == ra)) begin
                rs_data_o[k*XLEN +: XLEN] = wd_i[XLEN +: XLEN];
            end else if (BYP_EN && we_i[0] && (wa_i[0 +: AW] == ra)) begin
                rs_data_o[k*XLEN +: XLEN] = wd_i[0 +: XLEN];
            end else begin
                rs_data_o[k*XLEN +: XLEN] = regs_r[ra];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_addr_i     (rs_addr_i),
        .we_i          (we_i),
        .wa_i          (wa_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_rd_i    (alloc_rd_i),
        .rs_busy_o     (rs_busy_o),
        .alloc_ready_o (alloc_ready_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances (bypass, no bypass, four read ports)
// share one stimulus stream and are checked every cycle against an abstract model.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr2;
    logic [19:0] rs_addr4;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        av;
    logic [4:0]  ard;

    logic [63:0]  a_data;
    logic [1:0]   a_busy;
    logic         a_ready;
    logic [63:0]  b_data;
    logic [1:0]   b_busy;
    logic         b_ready;
    logic [127:0] c_data;
    logic [3:0]   c_busy;
    logic         c_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem    [32];
    logic        busy_m [32];

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr2), .rs_data_o(a_data), .rs_busy_o(a_busy),
        .we_i(we), .wa_i(wa), .wd_i(wd), .alloc_valid_i(av), .alloc_rd_i(ard), .alloc_ready_o(a_ready));

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr2), .rs_data_o(b_data), .rs_busy_o(b_busy),
        .we_i(we), .wa_i(wa), .wd_i(wd), .alloc_valid_i(av), .alloc_rd_i(ard), .alloc_ready_o(b_ready));

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr4), .rs_data_o(c_data), .rs_busy_o(c_busy),
        .we_i(we), .wa_i(wa), .wd_i(wd), .alloc_valid_i(av), .alloc_rd_i(ard), .alloc_ready_o(c_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [4:0] a);
        return (we[0] && wa[4:0] == a) || (we[1] && wa[9:5] == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we[1] && wa[9:5] == a) return wd[63:32];
        if (byp && we[0] && wa[4:0] == a) return wd[31:0];
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        return busy_m[a] && !(byp && hit(a));
    endfunction

    function automatic logic exp_ready(input logic [4:0] a);
        return !busy_m[a] || hit(a) || (a == 5'd0);
    endfunction

    // Abstract architectural state: register values and outstanding producers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                mem[r]    <= 32'd0;
                busy_m[r] <= 1'b0;
            end
        end else begin
            if (we[0] && wa[4:0] != 5'd0) mem[wa[4:0]] <= wd[31:0];
            if (we[1] && wa[9:5] != 5'd0) mem[wa[9:5]] <= wd[63:32];
            if (we[0]) busy_m[wa[4:0]] <= 1'b0;
            if (we[1]) busy_m[wa[9:5]] <= 1'b0;
            if (av && exp_ready(ard) && ard != 5'd0) busy_m[ard] <= 1'b1;
        end
    end

    // Every-cycle comparison of all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("A_data", a_data[k*32 +: 32], exp_data(rs_addr2[k*5 +: 5], 1'b1));
            chk("A_busy", 32'(a_busy[k]), 32'(exp_busy(rs_addr2[k*5 +: 5], 1'b1)));
            chk("B_data", b_data[k*32 +: 32], exp_data(rs_addr2[k*5 +: 5], 1'b0));
            chk("B_busy", 32'(b_busy[k]), 32'(exp_busy(rs_addr2[k*5 +: 5], 1'b0)));
        end
        for (int k = 0; k < 4; k++) begin
            chk("C_data", c_data[k*32 +: 32], exp_data(rs_addr4[k*5 +: 5], 1'b1));
            chk("C_busy", 32'(c_busy[k]), 32'(exp_busy(rs_addr4[k*5 +: 5], 1'b1)));
        end
        chk("A_ready", 32'(a_ready), 32'(exp_ready(ard)));
        chk("B_ready", 32'(b_ready), 32'(exp_ready(ard)));
        chk("C_ready", 32'(c_ready), 32'(exp_ready(ard)));
    end

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 2'b00;
        wa = 10'd0;
        wd = 64'd0;
        av = 1'b0;
        ard = 5'd0;
    endtask

    initial begin
        rst_n    = 1'b0;
        idle();
        rs_addr2 = {5'd0, 5'd5};
        rs_addr4 = {5'd31, 5'd1, 5'd1, 5'd0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", a_data[31:0], 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        rst_n = 1'b1;

        // write r5 and allocate it together, then reset asynchronously mid-cycle
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h55}; av = 1'b1; ard = 5'd5;
        nxt();
        idle();
        half();
        chk("r5_written", a_data[31:0], 32'h55);
        chk("r5_busy", 32'(a_busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr_data", a_data[31:0], 32'd0);
        chk("async_clr_busy", 32'(a_busy[0]), 32'd0);
        chk("async_clr_ready", 32'(a_ready), 32'd1);
        nxt();
        rst_n = 1'b1;

        // dual write to r7: port 1 wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; rs_addr2 = {5'd0, 5'd7};
        half();
        chk("dual_byp_A", a_data[31:0], 32'h22);
        chk("dual_old_B", b_data[31:0], 32'd0);
        nxt();
        idle();
        half();
        chk("dual_A", a_data[31:0], 32'h22);
        chk("dual_B", b_data[31:0], 32'h22);
        nxt();

        // write to r0 is dropped
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFF}; rs_addr2 = {5'd0, 5'd0};
        half();
        chk("r0_same", a_data[31:0], 32'd0);
        nxt();
        idle();
        half();
        chk("r0_next", a_data[31:0], 32'd0);
        nxt();

        // bypass on read port 1
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'hABCD}; rs_addr2 = {5'd3, 5'd0};
        half();
        chk("byp_A", a_data[63:32], 32'hABCD);
        chk("nobyp_B", b_data[63:32], 32'd0);
        nxt();
        idle();
        half();
        chk("nobyp_B_next", b_data[63:32], 32'hABCD);
        nxt();

        // RAW: allocate r9, then retire it
        av = 1'b1; ard = 5'd9; rs_addr2 = {5'd3, 5'd9};
        half();
        chk("alloc9_ready", 32'(a_ready), 32'd1);
        nxt();
        idle();
        half();
        chk("r9_busy_A", 32'(a_busy[0]), 32'd1);
        chk("r9_busy_B", 32'(b_busy[0]), 32'd1);
        nxt();
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'd5, 32'd0};
        half();
        chk("wb9_busy_A", 32'(a_busy[0]), 32'd0);
        chk("wb9_data_A", a_data[31:0], 32'd5);
        chk("wb9_busy_B", 32'(b_busy[0]), 32'd1);
        chk("wb9_data_B", b_data[31:0], 32'd0);
        nxt();
        idle();
        half();
        chk("r9_free_B", 32'(b_busy[0]), 32'd0);
        chk("r9_data_B", b_data[31:0], 32'd5);
        nxt();

        // WAW: reallocation blocked until the producer writes back
        av = 1'b1; ard = 5'd9;
        nxt();
        half();
        chk("waw_block_A", 32'(a_ready), 32'd0);
        chk("waw_block_B", 32'(b_ready), 32'd0);
        nxt();
        idle();
        half();
        chk("waw_still_busy", 32'(a_busy[0]), 32'd1);
        nxt();
        av = 1'b1; ard = 5'd9; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'd6};
        half();
        chk("waw_accept", 32'(a_ready), 32'd1);
        nxt();
        idle();
        half();
        chk("set_wins_busy", 32'(a_busy[0]), 32'd1);
        chk("set_wins_data", a_data[31:0], 32'd6);
        nxt();

        // allocation of r0 is accepted and changes nothing
        av = 1'b1; ard = 5'd0; rs_addr2 = {5'd0, 5'd0};
        half();
        chk("alloc0_ready", 32'(a_ready), 32'd1);
        nxt();
        idle();
        half();
        chk("alloc0_busy", 32'(a_busy[0]), 32'd0);
        nxt();

        // four read ports after writes to r1 and r31
        we = 2'b11; wa = {5'd31, 5'd1}; wd = {32'hFFFFFFFF, 32'd1};
        nxt();
        idle();
        half();
        chk("nrd4_p0", c_data[31:0], 32'd0);
        chk("nrd4_p1", c_data[63:32], 32'd1);
        chk("nrd4_p2", c_data[95:64], 32'd1);
        chk("nrd4_p3", c_data[127:96], 32'hFFFFFFFF);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
